multi_channel_fifo_arb: RTL and testbench

//  N-channel single-clock FIFO bank with round-robin read arbitration onto one output port.

---
 rtl/multi_channel_fifo_arb.sv | 145 ++++++++++++++
 tb/tb_multi_channel_fifo_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_fifo_arb.sv
// Per-channel FIFO bank merged onto one port by round-robin; pop data appears 1 cycle after grant.
// Backpressure: pop_enable gates grants; pushes to a full channel are dropped and counted.

module multi_channel_fifo_arb_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG_DEPTH  = 5
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  wr_vld,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] head_dat,
  output logic [LOG_DEPTH:0]    count
);
  logic [DATA_WIDTH-1:0] mem [2**LOG_DEPTH];
  logic [LOG_DEPTH-1:0]  wr_ptr;
  logic [LOG_DEPTH-1:0]  rd_ptr;

  // Callers gate wr_vld with ~full and rd_vld with ~empty.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld) wr_ptr <= wr_ptr + 1'b1;
      if (rd_vld) rd_ptr <= rd_ptr + 1'b1;
      if (wr_vld && !rd_vld)      count <= count + 1'b1;
      else if (!wr_vld && rd_vld) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld) mem[wr_ptr] <= wr_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

module multi_channel_fifo_arb #(
  parameter int N_CHANNELS   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int LOG_DEPTH    = 5,
  parameter int AFULL_THRESH = 28,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                                clk,
  input  logic                                clear,
  input  logic [N_CHANNELS-1:0]               push_en,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0]    push_data,
  output logic [N_CHANNELS-1:0]               almost_full,
  output logic [N_CHANNELS*(LOG_DEPTH+1)-1:0] fill,
  input  logic                                pop_enable,
  output logic                                pop_valid,
  output logic [DATA_WIDTH-1:0]               pop_data,
  output logic [$clog2(N_CHANNELS)-1:0]       pop_channel,
  output logic                                pop_empty,
  output logic [N_CHANNELS-1:0]               loss_out,
  output logic [N_CHANNELS-1:0]               error,
  output logic [N_CHANNELS*CNT_WIDTH-1:0]     loss_cnt
);
  localparam int CH_W  = $clog2(N_CHANNELS);
  localparam int CNT_W = LOG_DEPTH + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2**LOG_DEPTH);
  localparam logic [CNT_W-1:0] AFULL = CNT_W'(AFULL_THRESH);

  logic [N_CHANNELS-1:0][CNT_W-1:0]      ch_cnt;
  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] head_dat;
  logic [N_CHANNELS-1:0][CNT_WIDTH-1:0]  loss_q;
  logic [N_CHANNELS-1:0]                 full;
  logic [N_CHANNELS-1:0]                 empty;
  logic [N_CHANNELS-1:0]                 wr_vld;
  logic [N_CHANNELS-1:0]                 rd_vld;
  logic [N_CHANNELS-1:0]                 drop;
  logic                                  grant_vld;
  logic [CH_W-1:0]                       grant_idx;
  logic [CH_W-1:0]                       rr_ptr;

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
    // Full is taken from the start-of-cycle count, so a same-cycle pop never frees a slot.
    assign full[g]        = (ch_cnt[g] == DEPTH);
    assign empty[g]       = (ch_cnt[g] == '0);
    assign wr_vld[g]      = push_en[g] & ~full[g];
    assign drop[g]        = push_en[g] & full[g];
    assign rd_vld[g]      = grant_vld && (grant_idx == CH_W'(g));
    assign almost_full[g] = (ch_cnt[g] >= AFULL);
    assign fill[g*CNT_W +: CNT_W]             = ch_cnt[g];
    assign loss_cnt[g*CNT_WIDTH +: CNT_WIDTH] = loss_q[g];

    multi_channel_fifo_arb_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .LOG_DEPTH  (LOG_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .clear    (clear),
      .wr_vld   (wr_vld[g]),
      .wr_dat   (push_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .rd_vld   (rd_vld[g]),
      .head_dat (head_dat[g]),
      .count    (ch_cnt[g])
    );
  end

  assign pop_empty = &empty;

  // Search starts one past the last winner so each channel gets a turn.
  always_comb begin
    logic [CH_W-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 1; k <= N_CHANNELS; k++) begin
      idx = CH_W'((int'(rr_ptr) + k) % N_CHANNELS);
      if (pop_enable && !grant_vld && !empty[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      pop_valid   <= 1'b0;
      pop_data    <= '0;
      pop_channel <= '0;
      rr_ptr      <= CH_W'(N_CHANNELS - 1);
      loss_out    <= '0;
      error       <= '0;
      loss_q      <= '0;
    end else begin
      pop_valid <= grant_vld;
      if (grant_vld) begin
        pop_data    <= head_dat[grant_idx];
        pop_channel <= grant_idx;
        rr_ptr      <= grant_idx;
      end
      loss_out <= drop;
      error    <= error | drop;
      for (int i = 0; i < N_CHANNELS; i++) begin
        if (drop[i] && (loss_q[i] != '1)) loss_q[i] <= loss_q[i] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_multi_channel_fifo_arb.sv
// Directed bench for multi_channel_fifo_arb: N=4, 32-bit data, depth 32, 2-bit loss counters.

module tb_multi_channel_fifo_arb;
  logic         clk;
  logic         clear;
  logic [3:0]   push_en;
  logic [127:0] push_data;
  logic [3:0]   almost_full;
  logic [23:0]  fill;
  logic         pop_enable;
  logic         pop_valid;
  logic [31:0]  pop_data;
  logic [1:0]   pop_channel;
  logic         pop_empty;
  logic [3:0]   loss_out;
  logic [3:0]   error;
  logic [7:0]   loss_cnt;

  int checks = 0;
  int errors = 0;

  multi_channel_fifo_arb #(
    .N_CHANNELS   (4),
    .DATA_WIDTH   (32),
    .LOG_DEPTH    (5),
    .AFULL_THRESH (28),
    .CNT_WIDTH    (2)
  ) dut (
    .clk         (clk),
    .clear       (clear),
    .push_en     (push_en),
    .push_data   (push_data),
    .almost_full (almost_full),
    .fill        (fill),
    .pop_enable  (pop_enable),
    .pop_valid   (pop_valid),
    .pop_data    (pop_data),
    .pop_channel (pop_channel),
    .pop_empty   (pop_empty),
    .loss_out    (loss_out),
    .error       (error),
    .loss_cnt    (loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [31:0] dat, input logic [1:0] ch);
    chk({tag, " vld"}, 128'(pop_valid), 128'(1'b1));
    chk({tag, " dat"}, 128'(pop_data), 128'(dat));
    chk({tag, " ch"}, 128'(pop_channel), 128'(ch));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " pop_valid"}, 128'(pop_valid), 128'(1'b0));
    chk({tag, " pop_data"}, 128'(pop_data), 128'(0));
    chk({tag, " pop_channel"}, 128'(pop_channel), 128'(0));
    chk({tag, " pop_empty"}, 128'(pop_empty), 128'(1'b1));
    chk({tag, " fill"}, 128'(fill), 128'(0));
    chk({tag, " almost_full"}, 128'(almost_full), 128'(0));
    chk({tag, " loss_out"}, 128'(loss_out), 128'(0));
    chk({tag, " error"}, 128'(error), 128'(0));
    chk({tag, " loss_cnt"}, 128'(loss_cnt), 128'(0));
  endtask

  initial begin
    clear      = 1'b1;
    push_en    = '0;
    push_data  = '0;
    pop_enable = 1'b0;
    #1;
    chk_reset("reset");
    #13;
    clear = 1'b0;
    tick();

    // 1: two entries through ch0 with the consumer always ready
    pop_enable = 1'b1;
    push_en = 4'b0001; push_data[31:0] = 32'h11;
    tick();
    chk("t1 no pop yet", 128'(pop_valid), 128'(1'b0));
    chk("t1 fill0", 128'(fill[5:0]), 128'(1));
    chk("t1 not empty", 128'(pop_empty), 128'(1'b0));
    push_data[31:0] = 32'h22;
    tick();
    chk_pop("t1 pop0", 32'h11, 2'd0);
    push_en = '0;
    tick();
    chk_pop("t1 pop1", 32'h22, 2'd0);
    chk("t1 empty", 128'(pop_empty), 128'(1'b1));
    tick();
    chk("t1 idle vld", 128'(pop_valid), 128'(1'b0));
    chk("t1 hold dat", 128'(pop_data), 128'(32'h22));

    // Clear so the RR pointer starts at channel 0 again
    pop_enable = 1'b0;
    clear = 1'b1;
    #1;
    chk_reset("clr2");
    clear = 1'b0;

    // 2: two entries per channel, expect 0,1,2,3,0,1,2,3 with no gaps
    push_en = 4'b1111;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) push_data[i*32 +: 32] = 32'hC0 + 32'(16*r + i);
      tick();
    end
    push_en = '0;
    chk("t2 fill", 128'(fill), 128'({6'd2, 6'd2, 6'd2, 6'd2}));
    pop_enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_pop("t2 rr", 32'hC0 + 32'(16*(k/4) + k%4), 2'(k%4));
    end
    tick();
    chk("t2 drained vld", 128'(pop_valid), 128'(1'b0));
    chk("t2 drained empty", 128'(pop_empty), 128'(1'b1));

    // 3: only ch2 non-empty; after its grant RR_ptr=2 so ch3 beats ch1 next
    pop_enable = 1'b0;
    push_en = 4'b0100;
    push_data[95:64] = 32'h33; tick();
    push_data[95:64] = 32'h44; tick();
    push_en = '0;
    pop_enable = 1'b1;
    tick();
    chk_pop("t3 first", 32'h33, 2'd2);
    tick();
    chk_pop("t3 wrap", 32'h44, 2'd2);
    pop_enable = 1'b0;
    push_en = 4'b1010;
    push_data[63:32] = 32'hA1; push_data[127:96] = 32'hA3;
    tick();
    push_en = '0;
    pop_enable = 1'b1;
    tick();
    chk_pop("t3 after ch2", 32'hA3, 2'd3);
    tick();
    chk_pop("t3 then ch1", 32'hA1, 2'd1);
    pop_enable = 1'b0;
    tick();

    // 4: fill ch1, overflow by 3, then pop everything back
    push_en = 4'b0010;
    for (int k = 0; k < 32; k++) begin
      push_data[63:32] = 32'h1000 + 32'(k);
      tick();
      if (k == 26) chk("t4 afull@27", 128'(almost_full), 128'(0));
      if (k == 27) chk("t4 afull@28", 128'(almost_full), 128'(4'b0010));
    end
    chk("t4 fill32", 128'(fill[11:6]), 128'(32));
    chk("t4 no loss yet", 128'(loss_out), 128'(0));
    for (int d = 1; d <= 3; d++) begin
      push_en = 4'b0010; push_data[63:32] = 32'hBAD0 + 32'(d);
      tick();
      chk("t4 loss pulse", 128'(loss_out), 128'(4'b0010));
      push_en = '0;
      tick();
      chk("t4 loss gone", 128'(loss_out), 128'(0));
      chk("t4 loss_cnt", 128'(loss_cnt[3:2]), 128'(d));
    end
    chk("t4 error", 128'(error), 128'(4'b0010));
    chk("t4 fill still 32", 128'(fill[11:6]), 128'(32));
    // A same-cycle pop does not make room for this push
    pop_enable = 1'b1;
    push_en = 4'b0010; push_data[63:32] = 32'hDEAD;
    tick();
    push_en = '0;
    chk_pop("t4 pop0", 32'h1000, 2'd1);
    chk("t4 blocked push lost", 128'(loss_out), 128'(4'b0010));
    chk("t4 saturated", 128'(loss_cnt[3:2]), 128'(3));
    chk("t4 fill31", 128'(fill[11:6]), 128'(31));
    for (int k = 1; k < 32; k++) begin
      tick();
      chk_pop("t4 drain", 32'h1000 + 32'(k), 2'd1);
    end
    chk("t4 empty", 128'(pop_empty), 128'(1'b1));
    pop_enable = 1'b0;
    tick();

    // 5: 5 drops on ch3 with a 2-bit counter saturate at 3
    push_en = 4'b1000;
    for (int k = 0; k < 32; k++) begin
      push_data[127:96] = 32'h3000 + 32'(k);
      tick();
    end
    chk("t5 fill32", 128'(fill[23:18]), 128'(32));
    for (int d = 1; d <= 5; d++) begin
      tick();
      chk("t5 loss pulse", 128'(loss_out[3]), 128'(1'b1));
      chk("t5 loss_cnt", 128'(loss_cnt[7:6]), 128'(d > 3 ? 3 : d));
    end
    push_en = '0;
    tick(); tick();
    chk("t5 loss idle", 128'(loss_out), 128'(0));
    chk("t5 error sticky", 128'(error), 128'(4'b1010));

    // 6: clear mid-burst takes effect immediately
    pop_enable = 1'b1;
    tick();
    chk_pop("t6 pre", 32'h3000, 2'd3);
    tick();
    chk_pop("t6 pre2", 32'h3001, 2'd3);
    #2;
    clear = 1'b1;
    #1;
    chk_reset("t6 clear");
    clear = 1'b0;
    pop_enable = 1'b0;
    push_en = 4'b1001;
    push_data[31:0] = 32'h5A; push_data[127:96] = 32'h5B;
    tick();
    push_en = '0;
    pop_enable = 1'b1;
    tick();
    chk_pop("t6 first grant", 32'h5A, 2'd0);
    tick();
    chk_pop("t6 second grant", 32'h5B, 2'd3);
    pop_enable = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
